// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
package pipe_hazard_pkg;

  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned IDX_W          = 4;
  localparam int unsigned FWD_REGFILE    = 0;
  localparam int unsigned ALU_READY_DEF  = 0;
  localparam int unsigned LOAD_READY_DEF = 2;

  // One pending register write; addr is zero-extended from the core's AW.
  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  readyIdx;
  } entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Priority search over pending writes for one ID source operand.
module hazard_src_match
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned FW    = 2
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic [AW-1:0]      src,
  input  logic               used,
  output logic [FW-1:0]      sel_c,
  output logic               hazard_c
);

  // Scan oldest to youngest so the lowest matching index is what remains.
  always_comb begin
    sel_c    = FW'(FWD_REGFILE);
    hazard_c = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (used && (src != '0) && entries[i].wen && (entries[i].addr == ADDR_W'(src))) begin
        hazard_c = (i < int'(entries[i].readyIdx));
        sel_c    = hazard_c ? FW'(FWD_REGFILE) : FW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Tracks in-flight register writes behind ID; resolves forwarding selects and stalls.
module pipe_hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned AW         = 5,
  parameter int unsigned ALU_READY  = ALU_READY_DEF,
  parameter int unsigned LOAD_READY = LOAD_READY_DEF,
  localparam int unsigned FW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_en,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic             id_wen,
  input  logic [AW-1:0]    id_waddr,
  input  logic             id_is_load,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  output logic             stall,
  output logic [FW-1:0]    fwd_rs_sel,
  output logic [FW-1:0]    fwd_rt_sel,
  output logic [DEPTH-1:0] pend_valid,
  output logic [31:0]      stall_count
);

  entry_t [DEPTH-1:0] entries;
  entry_t             newEntry;
  logic               rsHazard;
  logic               rtHazard;

  hazard_src_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) rsMatch (
    .entries (entries),
    .src     (id_rs),
    .used    (id_rs_used),
    .sel_c   (fwd_rs_sel),
    .hazard_c(rsHazard)
  );

  hazard_src_match #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) rtMatch (
    .entries (entries),
    .src     (id_rt),
    .used    (id_rt_used),
    .sel_c   (fwd_rt_sel),
    .hazard_c(rtHazard)
  );

  // A squashed ID instruction never stalls; flush takes priority.
  assign stall = (rsHazard | rtHazard) & id_valid & ~id_flush;

  // Entry loaded into EX: the ID instruction, or a bubble when stalled/flushed/invalid.
  always_comb begin
    newEntry = '0;
    if (id_valid && !id_flush && !stall) begin
      newEntry.wen      = id_wen;
      newEntry.addr     = ADDR_W'(id_waddr);
      newEntry.readyIdx = id_is_load ? IDX_W'(LOAD_READY) : IDX_W'(ALU_READY);
    end
  end

  always_comb begin
    pend_valid = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pend_valid[i] = entries[i].wen;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      entries     <= '0;
      stall_count <= '0;
    end else if (cpu_en) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        entries[i] <= entries[i-1];
      end
      entries[0] <= newEntry;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a list model.
module tb_pipe_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpu_en, id_valid, id_flush, id_wen, id_is_load, id_rs_used, id_rt_used;
  logic [4:0]  id_waddr, id_rs, id_rt;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [2:0]  pend_valid;
  logic [31:0] stall_count;

  pipe_hazard_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_en     (cpu_en),
    .id_valid   (id_valid),
    .id_flush   (id_flush),
    .id_wen     (id_wen),
    .id_waddr   (id_waddr),
    .id_is_load (id_is_load),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .pend_valid (pend_valid),
    .stall_count(stall_count)
  );

  int     nChecks = 0;
  int     nPass   = 0;
  bit     chkEn   = 0;
  // Model: list of pending writes, index 0 = EX (youngest).
  bit     mW[3];
  int     mA[3];
  bit     mL[3];
  longint mCnt = 0;

  task automatic check(string nm, longint act, longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void resolve(input int src, input bit used, output int sel, output bit haz);
    bit found = 0;
    sel = 0;
    haz = 0;
    if (used && src != 0) begin
      for (int i = 0; i < 3; i++) begin
        if (!found && mW[i] && mA[i] == src) begin
          found = 1;
          if (i >= (mL[i] ? 2 : 0)) sel = i + 1;
          else haz = 1;
        end
      end
    end
  endfunction

  function automatic bit expStall();
    int s;
    bit hs, ht;
    resolve(int'(id_rs), id_rs_used, s, hs);
    resolve(int'(id_rt), id_rt_used, s, ht);
    return (hs || ht) && id_valid && !id_flush;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chkEn) begin
      int s;
      bit h;
      resolve(int'(id_rs), id_rs_used, s, h);
      check("fwd_rs_sel", longint'(fwd_rs_sel), longint'(s));
      resolve(int'(id_rt), id_rt_used, s, h);
      check("fwd_rt_sel", longint'(fwd_rt_sel), longint'(s));
      check("stall", longint'(stall), longint'(expStall()));
      check("pend_valid", longint'(pend_valid), longint'({mW[2], mW[1], mW[0]}));
      check("stall_count", longint'(stall_count), mCnt);
    end
  end

  task automatic drive(bit v, bit fl, bit we, int wa, bit ld, int rs, bit rsu, int rt, bit rtu);
    id_valid   = v;
    id_flush   = fl;
    id_wen     = we;
    id_waddr   = 5'(wa);
    id_is_load = ld;
    id_rs      = 5'(rs);
    id_rs_used = rsu;
    id_rt      = 5'(rt);
    id_rt_used = rtu;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit st;
    st = expStall();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin mW[i] = 0; mA[i] = 0; mL[i] = 0; end
      mCnt = 0;
    end else if (cpu_en) begin
      for (int i = 2; i > 0; i--) begin mW[i] = mW[i-1]; mA[i] = mA[i-1]; mL[i] = mL[i-1]; end
      if (id_valid && !id_flush && !st) begin
        mW[0] = id_wen; mA[0] = int'(id_waddr); mL[0] = id_is_load;
      end else begin
        mW[0] = 0; mA[0] = 0; mL[0] = 0;
      end
      if (st && mCnt != 64'hFFFF_FFFF) mCnt++;
    end
    #1;
  endtask

  task automatic randId();
    drive($urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
          int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin mW[i] = 0; mA[i] = 0; mL[i] = 0; end
    rst = 0;
    cpu_en = 1'($urandom_range(0, 1));
    randId();
    tick();
    chkEn = 1;
    randId();
    #1;
    check("reset stall", longint'(stall), 0);
    check("reset fwd_rs_sel", longint'(fwd_rs_sel), 0);
    check("reset fwd_rt_sel", longint'(fwd_rt_sel), 0);
    check("reset pend_valid", longint'(pend_valid), 0);
    check("reset stall_count", longint'(stall_count), 0);
    tick();
    rst = 1;
    cpu_en = 1;
    idle();
    repeat (3) tick();

    // ALU forwarding from EX, then from MEM
    drive(1, 0, 1, 3, 0, 1, 1, 2, 1);
    tick();
    drive(1, 0, 1, 6, 0, 3, 1, 0, 0);
    #1;
    check("alu rs sel", longint'(fwd_rs_sel), 1);
    check("alu stall", longint'(stall), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 3, 1);
    #1;
    check("alu rt sel mem", longint'(fwd_rt_sel), 2);
    tick();
    idle();
    repeat (3) tick();

    // Load-use: two stall cycles, then forward from WB
    drive(1, 0, 1, 4, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 7, 0, 0, 0, 4, 1);
    #1;
    check("lu stall1", longint'(stall), 1);
    check("lu pend1", longint'(pend_valid), 3'b001);
    tick();
    #1;
    check("lu stall2", longint'(stall), 1);
    check("lu pend2", longint'(pend_valid), 3'b010);
    tick();
    #1;
    check("lu stall3", longint'(stall), 0);
    check("lu rt sel wb", longint'(fwd_rt_sel), 3);
    check("lu count", longint'(stall_count), 2);
    check("lu bubbles", longint'(pend_valid), 3'b100);
    tick();
    idle();
    #1;
    check("lu issued", longint'(pend_valid), 3'b001);
    repeat (3) tick();

    // Youngest producer wins; register 0 and unused sources never forward
    drive(1, 0, 1, 5, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0);
    #1;
    check("youngest sel", longint'(fwd_rs_sel), 1);
    tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 1);
    #1;
    check("zero rs sel", longint'(fwd_rs_sel), 0);
    check("zero stall", longint'(stall), 0);
    drive(1, 0, 0, 0, 0, 5, 0, 0, 0);
    #1;
    check("unused rs sel", longint'(fwd_rs_sel), 0);
    tick();
    idle();
    repeat (3) tick();

    // Flush beats stall; cpu_en=0 freezes state mid-hazard
    drive(1, 0, 1, 4, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 9, 0, 0, 0, 4, 1);
    #1;
    check("flush stall", longint'(stall), 0);
    tick();
    drive(1, 0, 1, 9, 0, 0, 0, 4, 1);
    #1;
    check("flush bubble", longint'(pend_valid), 3'b010);
    check("hazard after flush", longint'(stall), 1);
    cpu_en = 0;
    repeat (3) begin
      tick();
      #1;
      check("frozen stall", longint'(stall), 1);
      check("frozen count", longint'(stall_count), 2);
      check("frozen pend", longint'(pend_valid), 3'b010);
    end
    cpu_en = 1;
    tick();
    #1;
    check("resume count", longint'(stall_count), 3);
    check("resume stall", longint'(stall), 0);
    check("resume rt sel", longint'(fwd_rt_sel), 3);
    tick();
    idle();
    repeat (3) tick();

    // Saturation: counter preloaded close to the top
    dut.stall_count = 32'hFFFF_FFFD;
    mCnt = 64'hFFFF_FFFD;
    repeat (3) begin
      drive(1, 0, 1, 4, 1, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
      repeat (3) tick();
    end
    idle();
    #1;
    check("saturated count", longint'(stall_count), 64'hFFFF_FFFF);
    rst = 0;
    tick();
    rst = 1;

    // Random traffic, including occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      cpu_en = ($urandom_range(0, 9) != 0);
      randId();
      tick();
    end

    chkEn = 0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
